// File: rtl/hex_display_pkg.sv
// ---------------------------------------------------------------------------
// hex_display_pkg
// Shared definitions for the hex display path (scanner and hex_ssd users).
//   NIBBLE_W     : width of one hex digit
//   scan_state_t : per-slot scan phase (dead-time gap / digit enabled)
//   DIG_OFF      : all-ones digit-enable pattern of a given width
//                  (active-low enables, so all-ones means every digit dark)
// No ports; import with hex_display_pkg::*.
// ---------------------------------------------------------------------------
package hex_display_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic {
        ST_GAP = 1'b0,
        ST_ON  = 1'b1
    } scan_state_t;

    // Builds an all-ones mask of 'width' bits (up to 64) in the low bits.
    // Callers slice the low bits out through a localparam.
    function automatic logic [63:0] DIG_OFF(input int width);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < width) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/hex_scan_timer.sv
// ---------------------------------------------------------------------------
// hex_scan_timer
// Slot timebase for the digit scanner. A slot counter runs 0..DIV-1 and the
// digit index advances on each wrap, DIGITS-1 back to 0 (the frame boundary).
// A two-phase FSM marks the dead-time gap at the start of every slot.
// Parameters: DIV (cycles per slot), GAP (dead-time cycles), DIGITS.
// Ports:
//   CLK        in   system clock
//   RESETN     in   asynchronous active-low reset
//   cnt_zero   out  high while the slot counter is 0
//   in_gap     out  high while the FSM is in ST_GAP
//   index      out  current digit index
//   frame_wrap out  high on the last cycle of the last slot of a frame
// ---------------------------------------------------------------------------
module hex_scan_timer
    import hex_display_pkg::*;
#(
    parameter int DIV    = 50000,
    parameter int GAP    = 2,
    parameter int DIGITS = 8
) (
    input  logic                      CLK,
    input  logic                      RESETN,
    output logic                      cnt_zero,
    output logic                      in_gap,
    output logic [$clog2(DIGITS)-1:0] index,
    output logic                      frame_wrap
);

    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(DIGITS);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [IW-1:0] index_next;
    logic          last_cnt;
    scan_state_t   state;
    scan_state_t   state_next;

    // Terminal counts are compared explicitly because DIV and DIGITS need
    // not be powers of two.
    assign last_cnt   = (cnt == CW'(DIV - 1));
    assign frame_wrap = last_cnt && (index == IW'(DIGITS - 1));
    assign cnt_zero   = (cnt == '0);
    assign in_gap     = (state == ST_GAP);

    // Slot counter and digit index registers.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            cnt   <= '0;
            index <= '0;
        end else begin
            cnt   <= cnt_next;
            index <= index_next;
        end
    end

    // Next counter/index: wrap the counter at DIV-1 and step the index,
    // wrapping it at DIGITS-1.
    always_comb begin
        cnt_next   = cnt + 1'b1;
        index_next = index;
        if (last_cnt) begin
            cnt_next   = '0;
            index_next = (index == IW'(DIGITS - 1)) ? '0 : index + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state <= ST_GAP;
        end else begin
            state <= state_next;
        end
    end

    // Next state follows the next counter value so that the state always
    // agrees with cnt: ST_GAP for cnt < GAP, ST_ON for the rest of the slot.
    always_comb begin
        state_next = ST_ON;
        if (cnt_next < CW'(GAP)) begin
            state_next = ST_GAP;
        end
    end

endmodule

// File: rtl/hex_digit_scanner.sv
// ---------------------------------------------------------------------------
// hex_digit_scanner
// Captures a multi-digit hex word, holds it tear-free and time-multiplexes
// it onto a single shared hex_ssd decoder, one nibble per refresh slot,
// with dead time between digits.
// Parameters: DIGITS (>=2), DIV (cycles per slot, >= GAP+1), GAP (>=1).
// Ports:
//   CLK      in   system clock
//   RESETN   in   asynchronous active-low reset
//   DATA     in   word to display, digit 0 in DATA[3:0]
//   LOAD     in   single-cycle capture strobe for DATA
//   PENDING  out  captured word not yet on display
//   BIN      out  registered nibble for hex_ssd
//   DIG      out  registered active-low one-hot digit enables
// Configuration: define HEX_LZB_EN for leading-zero blanking.
// ---------------------------------------------------------------------------
module hex_digit_scanner
    import hex_display_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int DIV    = 50000,
    parameter int GAP    = 2
) (
    input  logic                         CLK,
    input  logic                         RESETN,
    input  logic [NIBBLE_W*DIGITS-1:0]   DATA,
    input  logic                         LOAD,
    output logic                         PENDING,
    output logic [NIBBLE_W-1:0]          BIN,
    output logic [DIGITS-1:0]            DIG
);

    localparam int                IW           = $clog2(DIGITS);
    localparam logic [63:0]       DIG_OFF_WIDE = DIG_OFF(DIGITS);
    localparam logic [DIGITS-1:0] DIG_ALL      = DIG_OFF_WIDE[DIGITS-1:0];

    logic [NIBBLE_W*DIGITS-1:0] shadow;
    logic [NIBBLE_W*DIGITS-1:0] shown;
    logic                       cnt_zero;
    logic                       in_gap;
    logic                       frame_wrap;
    logic [IW-1:0]              index;
    logic [NIBBLE_W-1:0]        nib_sel;
    logic [DIGITS-1:0]          dig_on;

    hex_scan_timer #(
        .DIV    (DIV),
        .GAP    (GAP),
        .DIGITS (DIGITS)
    ) u_timer (
        .CLK        (CLK),
        .RESETN     (RESETN),
        .cnt_zero   (cnt_zero),
        .in_gap     (in_gap),
        .index      (index),
        .frame_wrap (frame_wrap)
    );

    // Capture path. The shadow takes every LOAD; the displayed word only
    // changes at a frame boundary, so a frame never mixes two words. A LOAD
    // on the boundary cycle transfers the old shadow and keeps PENDING high.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            shadow  <= '0;
            shown   <= '0;
            PENDING <= 1'b0;
        end else begin
            if (LOAD) begin
                shadow <= DATA;
            end
            if (frame_wrap && PENDING) begin
                shown <= shadow;
            end
            if (LOAD) begin
                PENDING <= 1'b1;
            end else if (frame_wrap) begin
                PENDING <= 1'b0;
            end
        end
    end

`ifdef HEX_LZB_EN
    logic [DIGITS-1:0] blank;
    logic              upper_zero;

    // A digit is blanked when it and every more significant nibble are zero.
    // Digit 0 is never blanked so a zero word still shows one "0".
    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (shown[NIBBLE_W*i +: NIBBLE_W] == '0);
            blank[i]   = upper_zero;
        end
    end
`endif

    // Select the nibble and one-hot enable for the current digit. With
    // blanking, ORing the mask in turns a blanked digit's low bit back off.
    always_comb begin
        nib_sel = '0;
        dig_on  = DIG_ALL;
        for (int i = 0; i < DIGITS; i++) begin
            if (index == IW'(i)) begin
                nib_sel   = shown[NIBBLE_W*i +: NIBBLE_W];
                dig_on[i] = 1'b0;
            end
        end
`ifdef HEX_LZB_EN
        dig_on = dig_on | blank;
`endif
    end

    // Output registers. BIN reloads only at slot start and is then steady
    // for the whole slot; DIG stays dark through the gap so the decoder
    // has settled on the new BIN before the digit turns on.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            BIN <= '0;
            DIG <= DIG_ALL;
        end else begin
            if (cnt_zero) begin
                BIN <= nib_sel;
            end
            DIG <= in_gap ? DIG_ALL : dig_on;
        end
    end

endmodule

// File: tb/tb_hex_digit_scanner.sv
// ---------------------------------------------------------------------------
// tb_hex_digit_scanner
// Self-checking bench for hex_digit_scanner with DIGITS=4, DIV=8, GAP=2.
// A cycle model pushes the expected BIN/DIG/PENDING into a scoreboard at
// each rising edge; the value is popped and compared on the falling edge.
// Directed checks with fixed values cover the reset state, scan order,
// tear-free update, boundary-cycle LOAD and asynchronous reset.
// Define HEX_LZB_EN for both the DUT and the bench to test blanking.
// ---------------------------------------------------------------------------
module tb_hex_digit_scanner;

    localparam int DIGITS = 4;
    localparam int DIV    = 8;
    localparam int GAP    = 2;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic        LOAD;
    logic [15:0] DATA;
    logic        PENDING;
    logic [3:0]  BIN;
    logic [3:0]  DIG;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] bin;
        logic [3:0] dig;
        logic       pend;
    } exp_t;

    exp_t sb[$];

    int          m_cnt;
    int          m_idx;
    logic [15:0] m_shadow;
    logic [15:0] m_shown;
    logic        m_pend;
    logic [3:0]  m_bin;
    logic [3:0]  m_dig;

    logic [3:0] scanNib [4] = '{4'hC, 4'h7, 4'hA, 4'h4};
    logic [3:0] scanDig [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    hex_digit_scanner #(
        .DIGITS (DIGITS),
        .DIV    (DIV),
        .GAP    (GAP)
    ) dut (
        .CLK     (CLK),
        .RESETN  (RESETN),
        .DATA    (DATA),
        .LOAD    (LOAD),
        .PENDING (PENDING),
        .BIN     (BIN),
        .DIG     (DIG)
    );

    // Free-running 10 ns clock.
    always #5 CLK = ~CLK;

    // Time limit so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached before the end of the sequence");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [3:0] nibOf(input logic [15:0] w, input int i);
        logic [15:0] t;
        t = w >> (4 * i);
        return t[3:0];
    endfunction

    // Expected enable pattern for digit idx while it is in its on phase.
    function automatic logic [3:0] modelDig(input int idx, input logic [15:0] sh);
        logic [3:0] d;
        d      = 4'hF;
        d[idx] = 1'b0;
`ifdef HEX_LZB_EN
        if (idx >= 1 && (sh >> (4 * idx)) == 16'h0000) begin
            d = 4'hF;
        end
`endif
        return d;
    endfunction

    task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_cnt    = 0;
        m_idx    = 0;
        m_shadow = 16'h0000;
        m_shown  = 16'h0000;
        m_pend   = 1'b0;
        m_bin    = 4'h0;
        m_dig    = 4'hF;
        sb.delete();
    endtask

    // One rising edge of the reference model; the expected outputs after
    // the edge go into the scoreboard.
    task automatic modelEdge(input logic ld, input logic [15:0] d);
        logic wrap;
        exp_t e;
        wrap = (m_cnt == DIV - 1) && (m_idx == DIGITS - 1);
        if (m_cnt == 0) begin
            m_bin = nibOf(m_shown, m_idx);
        end
        m_dig = (m_cnt < GAP) ? 4'hF : modelDig(m_idx, m_shown);
        if (wrap && m_pend) begin
            m_shown = m_shadow;
        end
        m_pend = ld ? 1'b1 : (wrap ? 1'b0 : m_pend);
        if (ld) begin
            m_shadow = d;
        end
        if (m_cnt == DIV - 1) begin
            m_cnt = 0;
            m_idx = (m_idx == DIGITS - 1) ? 0 : m_idx + 1;
        end else begin
            m_cnt++;
        end
        e.bin  = m_bin;
        e.dig  = m_dig;
        e.pend = m_pend;
        sb.push_back(e);
    endtask

    // Pops the oldest expectation and compares it with the DUT outputs.
    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard: observed empty queue, expected an entry");
        end else begin
            e = sb.pop_front();
            checkVal("sb_BIN", 16'(BIN), 16'(e.bin));
            checkVal("sb_DIG", 16'(DIG), 16'(e.dig));
            checkVal("sb_PENDING", 16'(PENDING), 16'(e.pend));
            checkVal("dig_onehot", 16'($countones(~DIG) <= 1), 16'h0001);
        end
    endtask

    // Drives one cycle from a falling edge to the next falling edge.
    task automatic applyStimulus(input logic ld, input logic [15:0] d);
        LOAD = ld;
        DATA = d;
        @(posedge CLK);
        modelEdge(ld, d);
        @(negedge CLK);
        checkOutput();
        LOAD = 1'b0;
    endtask

    // Steps idle cycles until the model says the DUT counter is at c in slot i.
    task automatic runUntil(input int c, input int i);
        for (int n = 0; n < 4 * DIGITS * DIV; n++) begin
            if (m_cnt == c && m_idx == i) begin
                return;
            end
            applyStimulus(1'b0, DATA);
        end
        checks++;
        errors++;
        $error("[TB] FAIL runUntil: observed no match, expected cnt %0d slot %0d", c, i);
    endtask

    initial begin
        RESETN = 1'b0;
        LOAD   = 1'b0;
        DATA   = 16'h0000;
        modelReset();

        // Reset state.
        repeat (10) @(negedge CLK);
        checkVal("reset_BIN", 16'(BIN), 16'h0000);
        checkVal("reset_DIG", 16'(DIG), 16'h000F);
        checkVal("reset_PENDING", 16'(PENDING), 16'h0000);

        // First slot after release: digit 0 on from cnt 3 through the next cnt 0.
        RESETN = 1'b1;
        runUntil(2, 0);
        checkVal("first_gap_DIG", 16'(DIG), 16'h000F);
        runUntil(3, 0);
        checkVal("first_on_DIG", 16'(DIG), 16'h000E);
        runUntil(0, 1);
        checkVal("slot_end_DIG", 16'(DIG), 16'h000E);
        runUntil(1, 1);
        checkVal("next_gap_DIG", 16'(DIG), 16'h000F);

        // Scan order.
        applyStimulus(1'b1, 16'h4A7C);
        checkVal("load_PENDING", 16'(PENDING), 16'h0001);
        runUntil(0, 0);
        for (int s = 0; s < 4; s++) begin
            runUntil(2, s);
            checkVal("scan_gap_DIG", 16'(DIG), 16'h000F);
            runUntil(4, s);
            checkVal("scan_BIN", 16'(BIN), 16'(scanNib[s]));
            checkVal("scan_DIG", 16'(DIG), 16'(scanDig[s]));
        end
        checkVal("scan_PENDING", 16'(PENDING), 16'h0000);

        // Tear-free update mid-frame.
        runUntil(3, 1);
        applyStimulus(1'b1, 16'h1234);
        checkVal("tear_PENDING", 16'(PENDING), 16'h0001);
        runUntil(4, 2);
        checkVal("tear_old_BIN2", 16'(BIN), 16'h000A);
        runUntil(4, 3);
        checkVal("tear_old_BIN3", 16'(BIN), 16'h0004);
        checkVal("tear_hold_PENDING", 16'(PENDING), 16'h0001);
        runUntil(4, 0);
        checkVal("tear_new_BIN0", 16'(BIN), 16'h0004);
        checkVal("tear_clr_PENDING", 16'(PENDING), 16'h0000);
        runUntil(4, 1);
        checkVal("tear_new_BIN1", 16'(BIN), 16'h0003);
        runUntil(4, 2);
        checkVal("tear_new_BIN2", 16'(BIN), 16'h0002);
        runUntil(4, 3);
        checkVal("tear_new_BIN3", 16'(BIN), 16'h0001);

        // LOAD on the frame-boundary cycle.
        applyStimulus(1'b1, 16'hAAAA);
        runUntil(7, 3);
        applyStimulus(1'b1, 16'h5555);
        checkVal("bnd_PENDING", 16'(PENDING), 16'h0001);
        runUntil(4, 0);
        checkVal("bnd_old_BIN0", 16'(BIN), 16'h000A);
        runUntil(4, 1);
        checkVal("bnd_old_BIN1", 16'(BIN), 16'h000A);
        runUntil(4, 0);
        checkVal("bnd_new_BIN0", 16'(BIN), 16'h0005);
        checkVal("bnd_new_PENDING", 16'(PENDING), 16'h0000);

        // Leading zeros: 0030 and then 0000.
        applyStimulus(1'b1, 16'h0030);
        runUntil(4, 0);
        checkVal("lz_DIG0", 16'(DIG), 16'h000E);
        runUntil(4, 1);
        checkVal("lz_BIN1", 16'(BIN), 16'h0003);
        checkVal("lz_DIG1", 16'(DIG), 16'h000D);
        runUntil(4, 2);
`ifdef HEX_LZB_EN
        checkVal("lz_DIG2", 16'(DIG), 16'h000F);
`else
        checkVal("lz_DIG2", 16'(DIG), 16'h000B);
`endif
        runUntil(4, 3);
`ifdef HEX_LZB_EN
        checkVal("lz_DIG3", 16'(DIG), 16'h000F);
`else
        checkVal("lz_DIG3", 16'(DIG), 16'h0007);
`endif
        applyStimulus(1'b1, 16'h0000);
        runUntil(4, 0);
        checkVal("zero_DIG0", 16'(DIG), 16'h000E);
        checkVal("zero_BIN0", 16'(BIN), 16'h0000);
        runUntil(4, 1);
`ifdef HEX_LZB_EN
        checkVal("zero_DIG1", 16'(DIG), 16'h000F);
`else
        checkVal("zero_DIG1", 16'(DIG), 16'h000D);
`endif
        applyStimulus(1'b1, 16'h0000);
        checkVal("same_data_PENDING", 16'(PENDING), 16'h0001);

        // Asynchronous reset during digit 2 on phase.
        runUntil(4, 2);
        checkVal("pre_reset_DIG", 16'(DIG), 16'h000B);
        #2;
        RESETN = 1'b0;
        #1;
        checkVal("async_BIN", 16'(BIN), 16'h0000);
        checkVal("async_DIG", 16'(DIG), 16'h000F);
        checkVal("async_PENDING", 16'(PENDING), 16'h0000);
        modelReset();
        @(negedge CLK);
        @(negedge CLK);
        RESETN = 1'b1;
        runUntil(4, 0);
        checkVal("restart_BIN0", 16'(BIN), 16'h0000);
        checkVal("restart_DIG0", 16'(DIG), 16'h000E);
        runUntil(4, 1);
        checkVal("restart_BIN1", 16'(BIN), 16'h0000);
        runUntil(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
